// File: rtl/titan_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// titan_ctrl_pkg
// Shared definitions for the Titan pipeline sequencing logic.
//   - PC source select codes, shared with the PC mux and pipeline registers
//   - FSM state encoding for titan_hazard_ctrl
//   - Packed strobe bundle used internally by the controller
// ---------------------------------------------------------------------------
package titan_ctrl_pkg;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_TRAP   = 2'b10;
    localparam logic [1:0] PC_XRET   = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_DRAIN    = 2'b01,
        ST_REDIRECT = 2'b10
    } ctrl_state_e;

    typedef struct packed {
        logic       if_stall;
        logic       id_stall;
        logic       id_flush;
        logic       ex_stall;
        logic       ex_flush;
        logic       mem_stall;
        logic       mem_flush;
        logic       wb_flush;
        logic [1:0] pc_sel;
        logic       trap_ack;
    } ctrl_strobes_t;

    // Bubble every pipeline register from IF/ID through MEM/WB; used when a
    // trap or xret is being taken and nothing in flight may retire.
    function automatic ctrl_strobes_t flush_pipeline();
        ctrl_strobes_t s;
        s           = '0;
        s.id_flush  = 1'b1;
        s.ex_flush  = 1'b1;
        s.mem_flush = 1'b1;
        s.wb_flush  = 1'b1;
        return s;
    endfunction

endpackage

// File: rtl/titan_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// titan_hazard_ctrl_if
// Bundle between the pipeline datapath and the hazard controller.
//   master : pipeline side, drives hazard sources, receives strobes
//   slave  : controller side, receives hazard sources, drives strobes
// Signals:
//   imem_busy, dmem_busy          memory wait states
//   id_rs1/rs2, id_use_rs1/rs2    ID operand usage
//   ex_rd, ex_mem_read            EX destination / load flag
//   ex_branch_taken               EX resolved taken branch or jump
//   mem_exception, mem_xret       MEM trap / return events
//   if/id/ex/mem stall, id/ex/mem/wb flush, pc_sel, trap_ack
//   stall_cycles                  saturating count of IF stall cycles
// ---------------------------------------------------------------------------
interface titan_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             imem_busy;
    logic             dmem_busy;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic             ex_branch_taken;
    logic             mem_exception;
    logic             mem_xret;

    logic             if_stall;
    logic             id_stall;
    logic             id_flush;
    logic             ex_stall;
    logic             ex_flush;
    logic             mem_stall;
    logic             mem_flush;
    logic             wb_flush;
    logic [1:0]       pc_sel;
    logic             trap_ack;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output imem_busy, dmem_busy, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               ex_rd, ex_mem_read, ex_branch_taken, mem_exception, mem_xret,
        input  if_stall, id_stall, id_flush, ex_stall, ex_flush, mem_stall,
               mem_flush, wb_flush, pc_sel, trap_ack, stall_cycles
    );

    modport slave (
        input  imem_busy, dmem_busy, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               ex_rd, ex_mem_read, ex_branch_taken, mem_exception, mem_xret,
        output if_stall, id_stall, id_flush, ex_stall, ex_flush, mem_stall,
               mem_flush, wb_flush, pc_sel, trap_ack, stall_cycles
    );
endinterface

// File: rtl/titan_loaduse_detect.sv
// ---------------------------------------------------------------------------
// titan_loaduse_detect
// Purely combinational load-use comparator. Flags when the instruction in
// ID reads a register that the load currently in EX has not produced yet.
// Ports:
//   i_id_rs1, i_id_rs2         ID source registers
//   i_id_use_rs1, i_id_use_rs2 ID instruction actually reads that source
//   i_ex_rd                    EX destination register
//   i_ex_mem_read              EX instruction is a load
//   o_load_use                 hazard present
// ---------------------------------------------------------------------------
module titan_loaduse_detect (
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_id_use_rs1,
    input  logic       i_id_use_rs2,
    input  logic [4:0] i_ex_rd,
    input  logic       i_ex_mem_read,
    output logic       o_load_use
);
    logic w_hitRs1;
    logic w_hitRs2;

    assign w_hitRs1 = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
    assign w_hitRs2 = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);

    // x0 is hardwired to zero, so a load targeting it never creates a hazard.
    assign o_load_use = i_ex_mem_read && (i_ex_rd != 5'd0) && (w_hitRs1 || w_hitRs2);
endmodule

// File: rtl/titan_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// titan_hazard_ctrl
// Central sequencing unit for the Titan 5-stage core. Produces every stall
// and flush strobe plus the PC source select, resolving load-use hazards,
// taken branches and memory wait states. A RUN/DRAIN/REDIRECT FSM handles
// traps and xret: drain outstanding memory activity, then redirect the PC
// for exactly one cycle while pulsing trap_ack.
// Ports:
//   i_clk      core clock
//   i_rst_n    asynchronous reset, active-low
//   io_ctrl    titan_hazard_ctrl_if.slave (hazard inputs, strobe outputs,
//              stall_cycles performance counter)
// ---------------------------------------------------------------------------
module titan_hazard_ctrl
    import titan_ctrl_pkg::*;
#(
    parameter int         CNT_W       = 32,
    parameter logic [1:0] TRAP_PC_SEL = PC_TRAP,
    parameter logic [1:0] XRET_PC_SEL = PC_XRET
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    titan_hazard_ctrl_if.slave   io_ctrl
);
    ctrl_state_e      r_state;
    ctrl_state_e      w_stateNext;
    logic             r_isXret;
    logic [CNT_W-1:0] r_stallCycles;
    logic             w_loadUse;
    logic             w_trapEvent;
    ctrl_strobes_t    w_strobes;

    titan_loaduse_detect u_loaduse (
        .i_id_rs1      (io_ctrl.id_rs1),
        .i_id_rs2      (io_ctrl.id_rs2),
        .i_id_use_rs1  (io_ctrl.id_use_rs1),
        .i_id_use_rs2  (io_ctrl.id_use_rs2),
        .i_ex_rd       (io_ctrl.ex_rd),
        .i_ex_mem_read (io_ctrl.ex_mem_read),
        .o_load_use    (w_loadUse)
    );

    assign w_trapEvent = io_ctrl.mem_exception || io_ctrl.mem_xret;

    // State register. The event kind is captured only on the RUN->DRAIN
    // transition; an exception wins over a simultaneous xret.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_RUN;
            r_isXret <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            if ((r_state == ST_RUN) && w_trapEvent) begin
                r_isXret <= io_ctrl.mem_xret && !io_ctrl.mem_exception;
            end
        end
    end

    // Next-state logic. DRAIN waits for both memory ports to go idle so no
    // stale fetch or data response lands after the redirect.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_RUN:      w_stateNext = w_trapEvent ? ST_DRAIN : ST_RUN;
            ST_DRAIN:    w_stateNext = (io_ctrl.imem_busy || io_ctrl.dmem_busy) ? ST_DRAIN : ST_REDIRECT;
            ST_REDIRECT: w_stateNext = ST_RUN;
            default:     w_stateNext = ST_RUN;
        endcase
    end

    // Output logic. In RUN the hazard sources are prioritised: trap event,
    // data wait, taken branch, then load-use and fetch wait (which combine,
    // with the IF/ID hold beating the IF/ID bubble).
    always_comb begin
        w_strobes        = '0;
        w_strobes.pc_sel = PC_SEQ;
        case (r_state)
            ST_RUN: begin
                if (w_trapEvent) begin
                    w_strobes          = flush_pipeline();
                    w_strobes.if_stall = 1'b1;
                end else if (io_ctrl.dmem_busy) begin
                    w_strobes.if_stall  = 1'b1;
                    w_strobes.id_stall  = 1'b1;
                    w_strobes.ex_stall  = 1'b1;
                    w_strobes.mem_stall = 1'b1;
                    w_strobes.wb_flush  = 1'b1;
                end else if (io_ctrl.ex_branch_taken) begin
                    w_strobes.pc_sel   = PC_BRANCH;
                    w_strobes.id_flush = 1'b1;
                    w_strobes.ex_flush = 1'b1;
                end else begin
                    if (w_loadUse) begin
                        w_strobes.if_stall = 1'b1;
                        w_strobes.id_stall = 1'b1;
                        w_strobes.ex_flush = 1'b1;
                    end
                    if (io_ctrl.imem_busy) begin
                        w_strobes.if_stall = 1'b1;
                        w_strobes.id_flush = !w_loadUse;
                    end
                end
            end
            ST_DRAIN: begin
                w_strobes          = flush_pipeline();
                w_strobes.if_stall = 1'b1;
            end
            ST_REDIRECT: begin
                w_strobes          = flush_pipeline();
                w_strobes.pc_sel   = r_isXret ? XRET_PC_SEL : TRAP_PC_SEL;
                w_strobes.trap_ack = 1'b1;
            end
            default: begin
                w_strobes        = '0;
                w_strobes.pc_sel = PC_SEQ;
            end
        endcase
    end

    // Saturating stall-cycle counter for the performance CSRs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stallCycles <= '0;
        end else if (w_strobes.if_stall && (r_stallCycles != {CNT_W{1'b1}})) begin
            r_stallCycles <= r_stallCycles + CNT_W'(1);
        end
    end

    assign io_ctrl.if_stall     = w_strobes.if_stall;
    assign io_ctrl.id_stall     = w_strobes.id_stall;
    assign io_ctrl.id_flush     = w_strobes.id_flush;
    assign io_ctrl.ex_stall     = w_strobes.ex_stall;
    assign io_ctrl.ex_flush     = w_strobes.ex_flush;
    assign io_ctrl.mem_stall    = w_strobes.mem_stall;
    assign io_ctrl.mem_flush    = w_strobes.mem_flush;
    assign io_ctrl.wb_flush     = w_strobes.wb_flush;
    assign io_ctrl.pc_sel       = w_strobes.pc_sel;
    assign io_ctrl.trap_ack     = w_strobes.trap_ack;
    assign io_ctrl.stall_cycles = r_stallCycles;
endmodule

// File: tb/tb_titan_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_titan_hazard_ctrl
// Self-checking bench for titan_hazard_ctrl. A behavioural model tracks the
// trap sequence and the stall counter; a negedge process compares every
// cycle. Directed sequences pin hand-computed values, then random traffic
// runs. The counter is narrowed to 4 bits so saturation is reachable.
// Output vector order: {if_stall, id_stall, id_flush, ex_stall, ex_flush,
//                       mem_stall, mem_flush, wb_flush, pc_sel[1:0], trap_ack}
// ---------------------------------------------------------------------------
module tb_titan_hazard_ctrl;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam logic [10:0] V_IDLE     = 11'b000_0000_0000;
    localparam logic [10:0] V_LOADUSE  = 11'b110_0100_0000;
    localparam logic [10:0] V_IMEM     = 11'b101_0000_0000;
    localparam logic [10:0] V_BRANCH   = 11'b001_0100_0010;
    localparam logic [10:0] V_DMEM     = 11'b110_1010_1000;
    localparam logic [10:0] V_TRAPEVT  = 11'b101_0101_1000;
    localparam logic [10:0] V_REDTRAP  = 11'b001_0101_1101;
    localparam logic [10:0] V_REDXRET  = 11'b001_0101_1111;

    logic clk;
    logic rst_n;
    logic [10:0] dutOuts;

    int nChecks;
    int nFails;

    // Model state: trap phase 0 = normal, 1 = draining, 2 = redirecting.
    int   mPhase;
    logic mTargetXret;
    int   mCount;

    titan_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

    titan_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_ctrl (hz)
    );

    assign dutOuts = {hz.if_stall, hz.id_stall, hz.id_flush, hz.ex_stall, hz.ex_flush,
                      hz.mem_stall, hz.mem_flush, hz.wb_flush, hz.pc_sel, hz.trap_ack};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    function automatic logic specLoadUse(input logic mr, input logic [4:0] rd,
                                         input logic u1, input logic [4:0] rs1,
                                         input logic u2, input logic [4:0] rs2);
        return mr && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    endfunction

    // Expected strobes straight from the priority rules.
    function automatic logic [10:0] modelOutputs(input int phase, input logic tgtXret,
                                                 input logic imem, input logic dmem,
                                                 input logic exc, input logic xr,
                                                 input logic br, input logic lu);
        logic ifS, idS, idF, exS, exF, memS, memF, wbF, ack;
        logic [1:0] pc;
        {ifS, idS, idF, exS, exF, memS, memF, wbF, ack} = '0;
        pc = 2'b00;
        if (phase == 1) begin
            {ifS, idF, exF, memF, wbF} = 5'b11111;
        end else if (phase == 2) begin
            {idF, exF, memF, wbF, ack} = 5'b11111;
            pc = tgtXret ? 2'b11 : 2'b10;
        end else if (exc || xr) begin
            {ifS, idF, exF, memF, wbF} = 5'b11111;
        end else if (dmem) begin
            {ifS, idS, exS, memS, wbF} = 5'b11111;
        end else if (br) begin
            pc = 2'b01;
            {idF, exF} = 2'b11;
        end else begin
            if (lu)   {ifS, idS, exF} = 3'b111;
            if (imem) begin
                ifS = 1'b1;
                if (!lu) idF = 1'b1;
            end
        end
        return {ifS, idS, idF, exS, exF, memS, memF, wbF, pc, ack};
    endfunction

    // Per-cycle comparison and model advance; inputs are stable from
    // posedge+1 until the next posedge, so the negedge sees this cycle's view.
    always @(negedge clk) begin
        logic [10:0] exp;
        logic lu;
        if (!rst_n) begin
            mPhase      = 0;
            mTargetXret = 1'b0;
            mCount      = 0;
        end else begin
            lu  = specLoadUse(hz.ex_mem_read, hz.ex_rd, hz.id_use_rs1, hz.id_rs1, hz.id_use_rs2, hz.id_rs2);
            exp = modelOutputs(mPhase, mTargetXret, hz.imem_busy, hz.dmem_busy,
                               hz.mem_exception, hz.mem_xret, hz.ex_branch_taken, lu);
            checkOutput("cycleStrobes", {21'd0, dutOuts}, {21'd0, exp});
            checkOutput("cycleStallCount", {28'd0, hz.stall_cycles}, mCount);
            if (exp[10] && mCount < CNT_MAX) mCount++;
            case (mPhase)
                0: if (hz.mem_exception || hz.mem_xret) begin
                       mPhase      = 1;
                       mTargetXret = hz.mem_xret && !hz.mem_exception;
                   end
                1: if (!(hz.imem_busy || hz.dmem_busy)) mPhase = 2;
                default: mPhase = 0;
            endcase
        end
    end

    task automatic driveInputs(input logic imem, input logic dmem,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2,
                               input logic [4:0] rd, input logic mr,
                               input logic br, input logic exc, input logic xr);
        hz.imem_busy       = imem;
        hz.dmem_busy       = dmem;
        hz.id_rs1          = rs1;
        hz.id_rs2          = rs2;
        hz.id_use_rs1      = u1;
        hz.id_use_rs2      = u2;
        hz.ex_rd           = rd;
        hz.ex_mem_read     = mr;
        hz.ex_branch_taken = br;
        hz.mem_exception   = exc;
        hz.mem_xret        = xr;
    endtask

    task automatic applyStimulus(input logic imem, input logic dmem,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2,
                                 input logic [4:0] rd, input logic mr,
                                 input logic br, input logic exc, input logic xr);
        @(posedge clk);
        #1;
        driveInputs(imem, dmem, rs1, rs2, u1, u2, rd, mr, br, exc, xr);
    endtask

    task automatic checkNow(input string name, input logic [10:0] expected);
        #3;
        checkOutput(name, {21'd0, dutOuts}, {21'd0, expected});
    endtask

    initial begin
        nChecks = 0;
        nFails  = 0;
        rst_n   = 1'b1;
        driveInputs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 rst_n = 1'b0;
        #2;
        checkOutput("resetStrobes", {21'd0, dutOuts}, 32'd0);
        checkOutput("resetCount", {28'd0, hz.stall_cycles}, 32'd0);

        // Pin the model against hand-derived vectors.
        checkOutput("modelLoadUse", {21'd0, modelOutputs(0, 0, 0, 0, 0, 0, 0, 1)}, {21'd0, V_LOADUSE});
        checkOutput("modelImemOnly", {21'd0, modelOutputs(0, 0, 1, 0, 0, 0, 0, 0)}, {21'd0, V_IMEM});
        checkOutput("modelXretRedirect", {21'd0, modelOutputs(2, 1, 0, 0, 0, 0, 0, 0)}, {21'd0, V_REDXRET});

        @(posedge clk);
        #2 rst_n = 1'b1;

        // Load-use for one cycle, then quiet.
        applyStimulus(0, 0, 5, 0, 1, 0, 5, 1, 0, 0, 0);
        checkNow("loadUse", V_LOADUSE);
        checkOutput("loadUseCountBefore", {28'd0, hz.stall_cycles}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkNow("afterLoadUse", V_IDLE);
        checkOutput("loadUseCountAfter", {28'd0, hz.stall_cycles}, 32'd1);

        // Branch wins over a concurrent load-use.
        applyStimulus(0, 0, 5, 0, 1, 0, 5, 1, 1, 0, 0);
        checkNow("branchOverLoadUse", V_BRANCH);

        // Data wait holds the branch for three cycles.
        repeat (3) begin
            applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
            checkNow("dmemHoldsBranch", V_DMEM);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        checkNow("branchAfterDmem", V_BRANCH);
        checkOutput("countAfterDmem", {28'd0, hz.stall_cycles}, 32'd4);

        // Load-use combined with fetch wait: hold IF/ID, no bubble.
        applyStimulus(1, 0, 0, 9, 0, 1, 9, 1, 0, 0, 0);
        checkNow("loadUsePlusImem", V_LOADUSE);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkNow("imemOnly", V_IMEM);
        applyStimulus(0, 0, 3, 0, 1, 0, 0, 1, 0, 0, 0);
        checkNow("loadToX0", V_IDLE);

        // Exception while the fetch port is busy.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkNow("excEvent", V_TRAPEVT);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkNow("excDrainBusy", V_TRAPEVT);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkNow("excDrainIdle", V_TRAPEVT);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkNow("excRedirect", V_REDTRAP);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkNow("excBackToRun", V_IDLE);

        // xret with idle memories; a new event during drain is ignored.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkNow("xretEvent", V_TRAPEVT);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkNow("xretDrain", V_TRAPEVT);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkNow("xretRedirect", V_REDXRET);

        // Exception and xret together: trap target.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        checkNow("bothEvent", V_TRAPEVT);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkNow("bothDrain", V_TRAPEVT);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkNow("bothRedirect", V_REDTRAP);

        // Reset in the middle of DRAIN.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkNow("rstExcEvent", V_TRAPEVT);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkNow("rstDrain", V_TRAPEVT);
        @(posedge clk);
        #2;
        driveInputs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        checkOutput("midDrainResetStrobes", {21'd0, dutOuts}, 32'd0);
        checkOutput("midDrainResetCount", {28'd0, hz.stall_cycles}, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            checkNow("noAckAfterReset", V_IDLE);
        end

        // Counter saturation.
        repeat (20) applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        checkOutput("countSaturated", {28'd0, hz.stall_cycles}, CNT_MAX);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(99) < 25, $urandom_range(99) < 20,
                          5'($urandom_range(7)), 5'($urandom_range(7)),
                          $urandom_range(1) == 1, $urandom_range(1) == 1,
                          5'($urandom_range(7)), $urandom_range(99) < 40,
                          $urandom_range(99) < 20, $urandom_range(99) < 5,
                          $urandom_range(99) < 5);
        end

        @(posedge clk);
        #1;
        driveInputs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule

// File: doc/titan_hazard_ctrl.md
Name: titan_hazard_ctrl

Overview:
Central pipeline sequencing unit for the Titan 5-stage core. It generates every stall and flush strobe for the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC-source select. It resolves load-use hazards, taken branches and memory wait states. It runs a small FSM that drains outstanding fetches and redirects to the trap or xret target when MEM reports an exception or xret. A saturating stall-cycle counter feeds the performance CSRs.

Parameters:
CNT_W, 32, width of stall_cycles counter
TRAP_PC_SEL, 2'b10, pc_sel code for trap vector
XRET_PC_SEL, 2'b11, pc_sel code for xret return

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-low
imem_busy  in  1  instruction fetch outstanding / not ready
dmem_busy  in  1  data access in MEM not complete
id_rs1  in  5  ID source register 1
id_rs2  in  5  ID source register 2
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_rd  in  5  EX destination register
ex_mem_read  in  1  EX instruction is a load
ex_branch_taken  in  1  EX resolved taken branch or jump
mem_exception  in  1  MEM instruction raises exception (includes if_exception propagated)
mem_xret  in  1  MEM instruction is mret/sret
if_stall  out  1  hold PC
id_stall  out  1  hold IF/ID
id_flush  out  1  bubble IF/ID (id_inst <= 32'h33)
ex_stall  out  1  hold ID/EX
ex_flush  out  1  bubble ID/EX
mem_stall  out  1  hold EX/MEM
mem_flush  out  1  bubble EX/MEM
wb_flush  out  1  bubble MEM/WB
pc_sel  out  2  00 seq, 01 branch, 10 trap, 11 xret
trap_ack  out  1  one-cycle pulse to CSR unit: trap/xret committed
stall_cycles  out  CNT_W  saturating count of cycles with if_stall=1

Behaviour:
- FSM states: RUN, DRAIN, REDIRECT. A 1-bit register is_xret latches the event kind on entry to DRAIN.
- Reset (rst=0, async): state=RUN, is_xret=0, stall_cycles=0. Outputs then follow the RUN equations; with all inputs 0 every output is 0 and pc_sel=00.
- Strobes and pc_sel are combinational from state and inputs; same-cycle effect. State and counter are registered.
- RUN priority, highest first:
  1. mem_exception|mem_xret: go to DRAIN next cycle and latch is_xret=mem_xret&!mem_exception (exception wins). In this cycle assert if_stall, id_flush, ex_flush, mem_flush and wb_flush; the excepting instruction must not write back.
  2. dmem_busy: if_stall, id_stall, ex_stall, mem_stall, wb_flush. Branch and load-use are ignored this cycle and re-evaluated later.
  3. ex_branch_taken: pc_sel=01, id_flush, ex_flush. A concurrent load-use is ignored.
  4. Load-use, when ex_mem_read & ex_rd!=0 & ((id_use_rs1&id_rs1==ex_rd)|(id_use_rs2&id_rs2==ex_rd)): if_stall, id_stall, ex_flush.
  5. imem_busy: if_stall, id_flush. This can combine with 4; stall takes precedence on IF/ID, so assert id_stall and not id_flush.
- DRAIN: if_stall, id_flush, ex_flush, mem_flush, wb_flush every cycle. Stay while imem_busy|dmem_busy; otherwise go to REDIRECT. New mem_exception/mem_xret are ignored because bubbles are flushed.
- REDIRECT, exactly 1 cycle: pc_sel = is_xret ? XRET_PC_SEL : TRAP_PC_SEL, trap_ack=1, id_flush, ex_flush, mem_flush, wb_flush, if_stall=0. Then go to RUN.
- trap_ack is asserted only in REDIRECT.
- stall_cycles increments on each posedge where if_stall=1 and holds at all-ones. It is reset only by rst.
- Reset mid-DRAIN/REDIRECT returns to RUN immediately; no trap_ack is emitted.
- Minimum trap latency is event cycle, then 1 DRAIN cycle, then REDIRECT, giving the target fetch 3 cycles after detection.

Decomposition:
- Shared package titan_ctrl_pkg holds the pc_sel codes (PC_SEQ, PC_BRANCH, PC_TRAP, PC_XRET) and the FSM state encoding. Pipeline registers and the PC mux import the same codes.
- One natural sub-module is titan_loaduse_detect: purely combinational comparator producing load_use.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for 1 cycle -> if_stall=id_stall=ex_flush=1 that cycle only; stall_cycles 0->1.
- Branch and load-use together: ex_branch_taken=1 with the load-use above -> pc_sel=01, id_flush=ex_flush=1, id_stall=0.
- dmem_busy=1 for 3 cycles with ex_branch_taken=1 -> pc_sel=00 and mem_stall=wb_flush=1 for 3 cycles; pc_sel=01 on cycle 4.
- mem_exception=1 with imem_busy=1 for 2 more cycles -> DRAIN for 2 cycles, then REDIRECT with pc_sel=10 and trap_ack=1 for exactly 1 cycle, then RUN.
- mem_xret=1 with both busy signals low -> next cycle DRAIN, then REDIRECT pc_sel=11, trap_ack=1. mem_xret and mem_exception both 1 -> pc_sel=10.
- Deassert rst during DRAIN -> all outputs 0, state RUN, stall_cycles=0 asynchronously, no trap_ack.
